// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters.
// Combinational fetch lookup, execute-stage resolution/recovery and saturating perf counters.
module branch_predictor #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCF,
  output logic              PredictionF,
  output logic [ADDR_W-1:0] PredictedPCF,
  input  logic              UpdateE,
  input  logic [ADDR_W-1:0] PCE,
  input  logic              TakenE,
  input  logic [ADDR_W-1:0] PCTargetE,
  input  logic              PredictedE,
  input  logic [ADDR_W-1:0] PredictedPCE,
  output logic              MispredictE,
  output logic [ADDR_W-1:0] RecoverPCE,
  output logic [31:0]       BranchCount,
  output logic [31:0]       MispredictCount
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [31:0]       CNT_MAX = 32'hFFFF_FFFF;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic [1:0]        ctr_r    [ENTRIES];

  logic [IDX_W-1:0]  idxF_s;
  logic [TAG_W-1:0]  tagF_s;
  logic              hitF_s;
  logic [IDX_W-1:0]  idxE_s;
  logic [TAG_W-1:0]  tagE_s;
  logic              hitE_s;
  logic [31:0]       branchCnt_r;
  logic [31:0]       mispCnt_r;

  function automatic logic [1:0] ctrInc(input logic [1:0] c);
    if (c == 2'b11) return 2'b11;
    else            return c + 2'b01;
  endfunction

  function automatic logic [1:0] ctrDec(input logic [1:0] c);
    if (c == 2'b00) return 2'b00;
    else            return c - 2'b01;
  endfunction

  // Fetch lookup: reads pre-update table contents, so same-cycle updates show up next cycle.
  always_comb begin
    idxF_s      = PCF[IDX_W+1:2];
    tagF_s      = PCF[ADDR_W-1:IDX_W+2];
    hitF_s      = valid_r[idxF_s] && (tag_r[idxF_s] == tagF_s);
    PredictionF = hitF_s && ctr_r[idxF_s][1];
    if (PredictionF) begin
      PredictedPCF = target_r[idxF_s];
    end else begin
      PredictedPCF = PCF + PC_STEP;
    end
  end

  // Execute-stage resolution: flush request and recovery PC, forced to zero when idle.
  always_comb begin
    idxE_s      = PCE[IDX_W+1:2];
    tagE_s      = PCE[ADDR_W-1:IDX_W+2];
    hitE_s      = valid_r[idxE_s] && (tag_r[idxE_s] == tagE_s);
    MispredictE = 1'b0;
    RecoverPCE  = {ADDR_W{1'b0}};
    if (UpdateE) begin
      MispredictE = (PredictedE != TakenE) || (TakenE && (PredictedPCE != PCTargetE));
      if (TakenE) begin
        RecoverPCE = PCTargetE;
      end else begin
        RecoverPCE = PCE + PC_STEP;
      end
    end else begin
      MispredictE = 1'b0;
      RecoverPCE  = {ADDR_W{1'b0}};
    end
  end

  // BTB update: train on hits, allocate only on taken misses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= {ADDR_W{1'b0}};
        ctr_r[i]    <= 2'b01;
      end
    end else if (UpdateE) begin
      if (hitE_s) begin
        if (TakenE) begin
          ctr_r[idxE_s]    <= ctrInc(ctr_r[idxE_s]);
          target_r[idxE_s] <= PCTargetE;
        end else begin
          ctr_r[idxE_s]    <= ctrDec(ctr_r[idxE_s]);
        end
      end else if (TakenE) begin
        valid_r[idxE_s]  <= 1'b1;
        tag_r[idxE_s]    <= tagE_s;
        target_r[idxE_s] <= PCTargetE;
        ctr_r[idxE_s]    <= 2'b10;
      end
    end
  end

  // Performance counters saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchCnt_r <= 32'd0;
      mispCnt_r   <= 32'd0;
    end else begin
      if (UpdateE && (branchCnt_r != CNT_MAX)) begin
        branchCnt_r <= branchCnt_r + 32'd1;
      end
      if (MispredictE && (mispCnt_r != CNT_MAX)) begin
        mispCnt_r <= mispCnt_r + 32'd1;
      end
    end
  end

  assign BranchCount     = branchCnt_r;
  assign MispredictCount = mispCnt_r;

endmodule
